// File: rtl/hdc_pkg.sv
// hdc_pkg: FSM state encoding, size defaults and label encoding shared by the HDC sequencer.
package hdc_pkg;
   typedef enum logic [1:0] {IDLE, FEED, CMP, FIN} state_t;
   localparam int MAX_LENGTH_DEF = 160;
   localparam int CHAR_W_DEF = 7;
   localparam int LEN_W_DEF = 8;
   localparam logic LABEL_HAM = 1'b0;
   localparam logic LABEL_SPAM = 1'b1;
endpackage

// File: rtl/hdc_char_mux.sv
// hdc_char_mux: picks character idx out of the latched packed message.
module hdc_char_mux
   import hdc_pkg::*;
#(
   parameter int MAX_LENGTH = MAX_LENGTH_DEF,
   parameter int CHAR_W = CHAR_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic [MAX_LENGTH*CHAR_W-1:0] msg,
   input  logic [LEN_W-1:0]             idx,
   output logic [CHAR_W-1:0]            ch
);
   always_comb begin
      ch = '0;
      for (int i = 0; i < MAX_LENGTH; i++)
         if (idx == LEN_W'(i)) ch = msg[i*CHAR_W +: CHAR_W];
   end
endmodule

// File: rtl/hdc_seq_ctrl.sv
// hdc_seq_ctrl: feeds a latched message to the HDC encoder one character at a time, then runs the HAM/SPAM compare.
// Optional CMP watchdog enabled by defining HDC_SEQ_TIMEOUT_EN.
module hdc_seq_ctrl
   import hdc_pkg::*;
#(
   parameter int MAX_LENGTH = MAX_LENGTH_DEF,
   parameter int CHAR_W = CHAR_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int CMP_TIMEOUT = 1023
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [MAX_LENGTH*CHAR_W-1:0] msg_data,
   input  logic [LEN_W-1:0]             msg_len,
   output logic                         busy,
   output logic                         char_valid,
   input  logic                         enc_ready,
   output logic [CHAR_W-1:0]            char_out,
   output logic [LEN_W-1:0]             char_idx,
   output logic                         char_first,
   output logic                         char_last,
   output logic                         cmp_start,
   input  logic                         cmp_done,
   input  logic                         cmp_is_spam,
   output logic                         done,
   output logic                         label,
   output logic                         err
);
   state_t state, state_nx;
   logic [MAX_LENGTH*CHAR_W-1:0] msg_q;
   logic [LEN_W-1:0] len_q, idx;
   logic [CHAR_W-1:0] ch;
   logic len_ok, at_last, hs, timeout;

   hdc_char_mux #(.MAX_LENGTH(MAX_LENGTH), .CHAR_W(CHAR_W), .LEN_W(LEN_W)) u_mux (
      .msg(msg_q),
      .idx(idx),
      .ch (ch)
   );

   assign len_ok = (len_q != '0) && (32'(len_q) <= MAX_LENGTH);
   assign at_last = idx == len_q - LEN_W'(1);
   assign hs = char_valid && enc_ready;

   always_comb begin
      state_nx = state;
      busy = state != IDLE;
      char_valid = state == FEED && len_ok;
      char_out = char_valid ? ch : '0;
      char_idx = char_valid ? idx : '0;
      char_first = char_valid && idx == '0;
      char_last = char_valid && at_last;
      done = state == FIN;
      case (state)
         IDLE:    state_nx = start ? FEED : IDLE;
         FEED:    state_nx = !len_ok ? FIN : (hs && at_last) ? CMP : FEED;
         CMP:     state_nx = (cmp_done || timeout) ? FIN : CMP;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         msg_q <= '0;
         len_q <= '0;
         idx <= '0;
         cmp_start <= 1'b0;
         label <= LABEL_HAM;
         err <= 1'b0;
      end else begin
         state <= state_nx;
         cmp_start <= state == FEED && state_nx == CMP;
         if (state == IDLE && start) begin
            msg_q <= msg_data;
            len_q <= msg_len;
            idx <= '0;
            label <= LABEL_HAM;
            err <= 1'b0;
         end
         // idx parks on the last character so it can never run past msg_len
         if (hs && !at_last) idx <= idx + LEN_W'(1);
         if (state == FEED && !len_ok) begin
            err <= 1'b1;
            label <= LABEL_HAM;
         end
         if (state == CMP && cmp_done) label <= cmp_is_spam ? LABEL_SPAM : LABEL_HAM;
         else if (state == CMP && timeout) begin
            err <= 1'b1;
            label <= LABEL_HAM;
         end
      end
   end

`ifdef HDC_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(CMP_TIMEOUT + 1);
   logic [TO_W-1:0] cmp_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cmp_cnt <= '0;
      else cmp_cnt <= (state == CMP) ? cmp_cnt + TO_W'(1) : '0;
   end

   assign timeout = state == CMP && cmp_cnt == TO_W'(CMP_TIMEOUT);
`else
   // no watchdog: constant-false for any legal CMP_TIMEOUT
   assign timeout = CMP_TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_hdc_seq_ctrl.sv
// tb_hdc_seq_ctrl: scoreboard bench for hdc_seq_ctrl; timeout scenario runs only with HDC_SEQ_TIMEOUT_EN.
module tb_hdc_seq_ctrl;
   logic clk, reset, start, enc_ready, cmp_done, cmp_is_spam;
   logic [1119:0] msg_data;
   logic [7:0] msg_len;
   logic busy, char_valid, char_first, char_last, cmp_start, done, label, err;
   logic [6:0] char_out;
   logic [7:0] char_idx;

   typedef struct {logic [6:0] ch; logic [7:0] idx; logic first; logic last; logic rdy; int cyc;} ev_t;
   typedef struct {logic [6:0] ch; logic [7:0] idx; logic first; logic last;} exp_t;
   ev_t vq[$];
   exp_t exp_q[$];
   logic [1119:0] msg;
   int cyc = 0;
   int tests = 0;
   int fails = 0;

   hdc_seq_ctrl #(.CMP_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .start(start), .msg_data(msg_data), .msg_len(msg_len),
      .busy(busy), .char_valid(char_valid), .enc_ready(enc_ready), .char_out(char_out),
      .char_idx(char_idx), .char_first(char_first), .char_last(char_last), .cmp_start(cmp_start),
      .cmp_done(cmp_done), .cmp_is_spam(cmp_is_spam), .done(done), .label(label), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (char_valid) vq.push_back('{char_out, char_idx, char_first, char_last, enc_ready, cyc});

   task automatic run_msg(input int len, input logic spam, input int stall_idx, input int stall_n,
                          input int poke, input int cmp_lat, output int s, output int cs_rel,
                          output int cs_n, output int done_rel, output logic d_label, output logic d_err);
      int stalls;
      vq.delete();
      exp_q.delete();
      if (len >= 1 && len <= 160)
         for (int i = 0; i < len; i++) exp_q.push_back('{msg[i*7 +: 7], 8'(i), i == 0, i == len - 1});
      @(posedge clk); #1;
      msg_data = msg; msg_len = 8'(len); start = 1'b1; enc_ready = 1'b1; cmp_is_spam = spam;
      s = cyc; cs_rel = -1; cs_n = 0; done_rel = -1; d_label = 1'bx; d_err = 1'bx; stalls = stall_n;
      for (int k = 1; k < 400 && done_rel < 0; k++) begin
         @(posedge clk); #1;
         start = (k == poke);
         if (k == poke) begin msg_len = 8'd5; msg_data = ~msg; end
         enc_ready = !(char_valid && char_idx == 8'(stall_idx) && stalls > 0);
         if (!enc_ready) stalls--;
         if (cmp_start) begin if (cs_rel < 0) cs_rel = k; cs_n++; end
         cmp_done = cmp_lat >= 0 && cs_rel >= 0 && k == cs_rel + cmp_lat;
         if (done) begin done_rel = k; d_label = label; d_err = err; end
      end
      start = 1'b0; cmp_done = 1'b0; enc_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 0; enc_ready = 1; cmp_done = 0; cmp_is_spam = 0; msg_data = '0; msg_len = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({busy, char_valid, char_out, char_idx, char_first, char_last, cmp_start, done, label, err} !== '0) begin
         fails++; $display("FAIL reset_outputs got busy=%b cv=%b idx=%0d done=%b label=%b err=%b exp all 0",
                           busy, char_valid, char_idx, done, label, err);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle busy got %b exp 0", busy); end
   endtask

   task automatic test_basic();
      int s, cs, csn, dr; logic dl, de; exp_t e;
      msg = '0; msg[6:0] = 7'h41; msg[13:7] = 7'h42; msg[20:14] = 7'h43;
      run_msg(3, 1'b1, -1, 0, 0, 2, s, cs, csn, dr, dl, de);
      foreach (vq[i]) if (vq[i].rdy) begin
         tests++;
         if (exp_q.size() == 0) begin fails++; $display("FAIL basic_extra got idx=%0d exp none", vq[i].idx); end
         else begin
            e = exp_q.pop_front();
            if ({vq[i].ch, vq[i].idx, vq[i].first, vq[i].last} !== {e.ch, e.idx, e.first, e.last}) begin
               fails++; $display("FAIL basic_hs got ch=%h idx=%0d f=%b l=%b exp ch=%h idx=%0d f=%b l=%b",
                  vq[i].ch, vq[i].idx, vq[i].first, vq[i].last, e.ch, e.idx, e.first, e.last);
            end
         end
      end
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL basic_missing got %0d left exp 0", exp_q.size()); end
      tests++;
      if (vq.size() != 3 || vq[0].cyc - s != 1 || vq[2].cyc - s != 3) begin
         fails++; $display("FAIL basic_char_timing got n=%0d exp chars on cycles 1-3", vq.size());
      end
      tests++;
      if (cs != 4 || csn != 1) begin fails++; $display("FAIL basic_cmp_start got cyc=%0d n=%0d exp cyc=4 n=1", cs, csn); end
      tests++;
      if (dr != 7) begin fails++; $display("FAIL basic_done_cycle got %0d exp 7", dr); end
      tests++;
      if ({dl, de} !== 2'b10) begin fails++; $display("FAIL basic_label got label=%b err=%b exp 1 0", dl, de); end
   endtask

   task automatic test_stall();
      int s, cs, csn, dr, n1; logic dl, de; exp_t e;
      for (int i = 0; i < 160; i++) msg[i*7 +: 7] = 7'($urandom);
      run_msg(4, 1'b0, 1, 2, 0, 2, s, cs, csn, dr, dl, de);
      n1 = 0;
      foreach (vq[i]) begin
         if (vq[i].idx == 8'd1) n1++;
         if (vq[i].rdy) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL stall_extra got idx=%0d exp none", vq[i].idx); end
            else begin
               e = exp_q.pop_front();
               if ({vq[i].ch, vq[i].idx, vq[i].first, vq[i].last} !== {e.ch, e.idx, e.first, e.last}) begin
                  fails++; $display("FAIL stall_hs got ch=%h idx=%0d f=%b l=%b exp ch=%h idx=%0d f=%b l=%b",
                     vq[i].ch, vq[i].idx, vq[i].first, vq[i].last, e.ch, e.idx, e.first, e.last);
               end
            end
         end
      end
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL stall_missing got %0d left exp 0", exp_q.size()); end
      tests++;
      if (n1 != 3) begin fails++; $display("FAIL stall_hold got %0d cycles at idx1 exp 3", n1); end
      tests++;
      if ({dl, de} !== 2'b00 || dr < 0) begin fails++; $display("FAIL stall_done got label=%b err=%b rel=%0d exp 0 0", dl, de, dr); end
   endtask

   task automatic test_bad_len();
      int s, cs, csn, dr; logic dl, de;
      int lens[2] = '{0, 161};
      foreach (lens[j]) begin
         run_msg(lens[j], 1'b1, -1, 0, 0, 2, s, cs, csn, dr, dl, de);
         tests++;
         if (vq.size() != 0) begin fails++; $display("FAIL badlen%0d_valid got %0d chars exp 0", lens[j], vq.size()); end
         tests++;
         if (dr != 2) begin fails++; $display("FAIL badlen%0d_done got %0d exp 2", lens[j], dr); end
         tests++;
         if ({dl, de} !== 2'b01) begin fails++; $display("FAIL badlen%0d_flags got label=%b err=%b exp 0 1", lens[j], dl, de); end
      end
   endtask

   task automatic test_max_len();
      int s, cs, csn, dr, nh; logic dl, de; exp_t e;
      for (int i = 0; i < 160; i++) msg[i*7 +: 7] = 7'($urandom);
      run_msg(160, 1'b1, -1, 0, 0, 3, s, cs, csn, dr, dl, de);
      nh = 0;
      foreach (vq[i]) if (vq[i].rdy) begin
         nh++;
         e = exp_q.size() != 0 ? exp_q.pop_front() : '{7'h0, 8'hff, 1'b0, 1'b0};
         tests++;
         if ({vq[i].ch, vq[i].idx, vq[i].first, vq[i].last} !== {e.ch, e.idx, e.first, e.last}) begin
            fails++; $display("FAIL max_hs got ch=%h idx=%0d f=%b l=%b exp ch=%h idx=%0d f=%b l=%b",
               vq[i].ch, vq[i].idx, vq[i].first, vq[i].last, e.ch, e.idx, e.first, e.last);
         end
      end
      tests++;
      if (nh != 160 || exp_q.size() != 0) begin fails++; $display("FAIL max_count got %0d handshakes exp 160", nh); end
      tests++;
      if ({dl, de} !== 2'b10 || cs != 161) begin fails++; $display("FAIL max_done got label=%b err=%b cs=%0d exp 1 0 161", dl, de, cs); end
   endtask

   task automatic test_back_to_back();
      int s, cs, csn, dr; logic dl, de; exp_t e;
      int lens[2] = '{8, 5};
      logic spams[2] = '{1'b0, 1'b1};
      foreach (lens[j]) begin
         for (int i = 0; i < 160; i++) msg[i*7 +: 7] = 7'($urandom);
         run_msg(lens[j], spams[j], -1, 0, j == 0 ? 3 : 0, 1, s, cs, csn, dr, dl, de);
         foreach (vq[i]) if (vq[i].rdy) begin
            e = exp_q.size() != 0 ? exp_q.pop_front() : '{7'h0, 8'hff, 1'b0, 1'b0};
            tests++;
            if ({vq[i].ch, vq[i].idx, vq[i].first, vq[i].last} !== {e.ch, e.idx, e.first, e.last}) begin
               fails++; $display("FAIL b2b%0d_hs got ch=%h idx=%0d f=%b l=%b exp ch=%h idx=%0d f=%b l=%b", j,
                  vq[i].ch, vq[i].idx, vq[i].first, vq[i].last, e.ch, e.idx, e.first, e.last);
            end
         end
         tests++;
         if (exp_q.size() != 0) begin fails++; $display("FAIL b2b%0d_missing got %0d left exp 0", j, exp_q.size()); end
         tests++;
         if ({dl, de} !== {spams[j], 1'b0} || dr != lens[j] + 3) begin
            fails++; $display("FAIL b2b%0d_done got label=%b err=%b rel=%0d exp %b 0 %0d", j, dl, de, dr, spams[j], lens[j] + 3);
         end
      end
   endtask

   task automatic test_reset_mid();
      int s, cs, csn, dr; logic dl, de;
      for (int i = 0; i < 160; i++) msg[i*7 +: 7] = 7'($urandom);
      @(posedge clk); #1;
      msg_data = msg; msg_len = 8'd100; start = 1'b1; enc_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 100 && !(char_valid && char_idx == 8'd50); k++) begin @(posedge clk); #1; end
      tests++;
      if (!(char_valid && char_idx == 8'd50)) begin fails++; $display("FAIL rstmid_reach got idx=%0d exp 50", char_idx); end
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({busy, char_valid, char_out, char_idx, char_first, char_last, cmp_start, done, label, err} !== '0) begin
         fails++; $display("FAIL rstmid_outputs got busy=%b cv=%b idx=%0d exp all 0", busy, char_valid, char_idx);
      end
      @(posedge clk); #1 reset = 1'b0;
      run_msg(1, 1'b1, -1, 0, 0, 2, s, cs, csn, dr, dl, de);
      tests++;
      if (vq.size() != 1 || !vq[0].rdy || vq[0].ch !== msg[6:0] || vq[0].idx !== 8'd0 || {vq[0].first, vq[0].last} !== 2'b11) begin
         fails++; $display("FAIL rstmid_len1_char got n=%0d exp one char idx 0 first=1 last=1", vq.size());
      end
      tests++;
      if (dr != 5 || {dl, de} !== 2'b10) begin fails++; $display("FAIL rstmid_len1_done got rel=%0d label=%b err=%b exp 5 1 0", dr, dl, de); end
   endtask

`ifdef HDC_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int s, cs, csn, dr; logic dl, de;
      for (int i = 0; i < 160; i++) msg[i*7 +: 7] = 7'($urandom);
      run_msg(2, 1'b1, -1, 0, 5, -1, s, cs, csn, dr, dl, de);
      tests++;
      if (cs != 3 || dr != cs + 16) begin fails++; $display("FAIL timeout_done got cs=%0d rel=%0d exp 3 19", cs, dr); end
      tests++;
      if ({dl, de} !== 2'b01) begin fails++; $display("FAIL timeout_flags got label=%b err=%b exp 0 1", dl, de); end
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL timeout_ignored_start got busy=%b exp 0", busy); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_bad_len();
      test_max_len();
      test_back_to_back();
      test_reset_mid();
`ifdef HDC_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion exp finish");
      $fatal(1);
   end
endmodule
